// File: rtl/periph_reg_fabric.sv
// periph_reg_fabric: single-outstanding register bus bridge from one master
// to NUM_SLV peripheral slots, with ack timeout, decode error and error stats.
module periph_reg_fabric #(
  parameter int unsigned NUM_SLV  = 5,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned SLV_AW   = 6,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic                      app_clk,
  input  logic                      app_rst,
  input  logic                      reg_cs,
  input  logic                      reg_wr,
  input  logic [SEL_W+SLV_AW-1:0]   reg_addr,
  input  logic [31:0]               reg_wdata,
  input  logic [3:0]                reg_be,
  output logic [31:0]               reg_rdata,
  output logic                      reg_ack,
  output logic                      reg_err,
  output logic [NUM_SLV-1:0]        slv_cs,
  output logic                      slv_wr,
  output logic [SLV_AW-1:0]         slv_addr,
  output logic [31:0]               slv_wdata,
  output logic [3:0]                slv_be,
  input  logic [NUM_SLV*32-1:0]     slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  input  logic                      err_clr,
  output logic                      err_sticky,
  output logic [7:0]                err_cnt
);

  localparam int unsigned AW    = SEL_W + SLV_AW;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     slot_q, slot_d;
  logic                 wr_q, wr_d;
  logic [SLV_AW-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLV-1:0]   cs_q, cs_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 sticky_q, sticky_d;
  logic [7:0]           ecnt_q, ecnt_d;

  logic [SEL_W-1:0]     slot_in;
  logic                 slot_ok;
  logic [NUM_SLV-1:0]   onehot_in;
  logic                 sel_ack;
  logic [31:0]          sel_rdata;
  logic                 err_now;

  assign slot_in = reg_addr[AW-1 -: SEL_W];

  // Slot decode of the incoming address and mux of the selected slave's response
  always_comb begin
    slot_ok   = 32'(slot_in) < NUM_SLV;
    onehot_in = '0;
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (slot_in == SEL_W'(i)) onehot_in[i] = 1'b1;
      if (slot_q == SEL_W'(i)) begin
        sel_ack   = slv_ack[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    cs_d    = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (reg_cs) begin
          slot_d  = slot_in;
          wr_d    = reg_wr;
          addr_d  = reg_addr[SLV_AW-1:0];
          wdata_d = reg_wdata;
          be_d    = reg_be;
          if (slot_ok) begin
            state_d = S_REQ;
            cs_d    = onehot_in;
            cnt_d   = '0;
          end else begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = reg_wr ? 32'd0 : ERR_DATA;
          end
        end
      end
      S_REQ: begin
        if (!reg_cs) begin
          // master withdrew: drop the select silently
          state_d = S_IDLE;
        end else if (sel_ack) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          rdata_d = wr_q ? 32'd0 : sel_rdata;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = wr_q ? 32'd0 : ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          cs_d  = cs_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Error status: sticky flag and saturating count, clear loses to a new error
  always_comb begin
    err_now  = (state_q == S_RESP) && err_q;
    sticky_d = sticky_q;
    ecnt_d   = ecnt_q;
    if (err_clr) begin
      sticky_d = err_now;
      ecnt_d   = err_now ? 8'd1 : 8'd0;
    end else if (err_now) begin
      sticky_d = 1'b1;
      ecnt_d   = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      cs_q     <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      sticky_q <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      sticky_q <= sticky_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_ack    = ack_q;
  assign reg_err    = err_q;
  assign slv_cs     = cs_q;
  assign slv_wr     = wr_q;
  assign slv_addr   = addr_q;
  assign slv_wdata  = wdata_q;
  assign slv_be     = be_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_periph_reg_fabric.sv
// Bench for periph_reg_fabric: per-transaction timeline model plus literal pins.
`timescale 1ns/1ps
module tb_periph_reg_fabric;

  localparam int NS = 5;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_DEAD;

  logic        app_clk = 1'b0;
  logic        app_rst;
  logic        reg_cs, reg_wr;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack, reg_err;
  logic [4:0]  slv_cs;
  logic        slv_wr;
  logic [5:0]  slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_be;
  logic [159:0] slv_rdata;
  logic [4:0]  slv_ack;
  logic        err_clr, err_sticky;
  logic [7:0]  err_cnt;

  periph_reg_fabric #(.NUM_SLV(5), .SEL_W(3), .SLV_AW(6), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .app_clk(app_clk), .app_rst(app_rst), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
    .slv_cs(slv_cs), .slv_wr(slv_wr), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_be(slv_be), .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .err_clr(err_clr), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 app_clk = ~app_clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // expected outputs for the current cycle
  logic [4:0]  e_cs;
  logic        e_ack, e_err, e_wr, e_sticky;
  logic [31:0] e_rdata, e_wdata;
  logic [5:0]  e_addr;
  logic [3:0]  e_be;
  logic [7:0]  e_cnt;

  // model state: visible request copies and error statistics
  logic        m_wr, m_sticky;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  int          m_cnt;

  bit          clr_en = 0;
  bit          pin_en = 0;
  logic [31:0] pin_val;
  bit          clr_at_resp = 0;

  logic [31:0] last_rdata;
  logic        last_err;
  logic [4:0]  last_cs;
  int          cs_hi;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // single compare process, mid-cycle
  always @(negedge app_clk) begin
    if (chk_en) begin
      chk("slv_cs", 32'(slv_cs), 32'(e_cs));
      chk("reg_ack", 32'(reg_ack), 32'(e_ack));
      chk("reg_err", 32'(reg_err), 32'(e_err));
      chk("reg_rdata", reg_rdata, e_rdata);
      chk("slv_wr", 32'(slv_wr), 32'(e_wr));
      chk("slv_addr", 32'(slv_addr), 32'(e_addr));
      chk("slv_wdata", slv_wdata, e_wdata);
      chk("slv_be", 32'(slv_be), 32'(e_be));
      chk("err_sticky", 32'(err_sticky), 32'(e_sticky));
      chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
      if (reg_ack) begin
        last_rdata = reg_rdata;
        last_err   = reg_err;
      end
      if (slv_cs != 5'd0) begin
        last_cs = slv_cs;
        cs_hi++;
      end
    end
  end

  task automatic model_reset();
    m_wr = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_sticky = 0; m_cnt = 0;
  endtask

  // one clock cycle: publish expectations, then advance the model at the edge
  task automatic step(input logic [4:0] cs, input logic ack, input logic err, input logic [31:0] rd);
    e_cs = cs; e_ack = ack; e_err = err; e_rdata = rd;
    e_wr = m_wr; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
    e_sticky = m_sticky; e_cnt = 8'(m_cnt);
    @(posedge app_clk);
    if (app_rst) model_reset();
    else if (err_clr) begin
      m_sticky = ack & err;
      m_cnt    = (ack && err) ? 1 : 0;
    end else if (ack && err) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  task automatic rand_inputs();
    err_clr = clr_en ? ($urandom_range(0, 7) == 0) : 1'b0;
    slv_ack = 5'($urandom);
    for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      reg_cs = 0; reg_wr = 1'($urandom); reg_addr = 9'($urandom);
      reg_wdata = $urandom; reg_be = 4'($urandom);
      step(5'd0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  // d: REQ cycles before the slave acks (>= TO means never); a: abort REQ cycle or -1
  task automatic do_txn(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int d, input int a, input bit hold);
    int slot, n;
    logic er;
    logic [31:0] cap;
    logic [4:0] oh;
    slot = int'(addr[8:6]);
    cap = 0;
    rand_inputs();
    reg_cs = 1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
    step(5'd0, 1'b0, 1'b0, 32'd0);
    m_wr = wr; m_addr = addr[5:0]; m_wdata = wd; m_be = be;
    if (slot >= NS) begin
      rand_inputs();
      if (clr_at_resp) err_clr = 1;
      reg_cs = hold;
      step(5'd0, 1'b1, 1'b1, wr ? 32'd0 : ERRD);
      return;
    end
    oh = 5'(1 << slot);
    n  = (d < TO) ? d + 1 : TO;
    er = (d >= TO);
    for (int j = 0; j < n; j++) begin
      rand_inputs();
      slv_ack[slot] = (j == d);
      if (j == d && pin_en) slv_rdata[32*slot +: 32] = pin_val;
      if (j == d) cap = slv_rdata[32*slot +: 32];
      if (j == a) begin
        reg_cs = 0;
        slv_ack[slot] = 0;
        step(oh, 1'b0, 1'b0, 32'd0);
        idle(1);
        return;
      end
      step(oh, 1'b0, 1'b0, 32'd0);
    end
    rand_inputs();
    if (clr_at_resp) err_clr = 1;
    reg_cs = hold;
    step(5'd0, 1'b1, er, wr ? 32'd0 : (er ? ERRD : cap));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int slot, d, a;
    app_rst = 1; reg_cs = 0; reg_wr = 0; reg_addr = 0; reg_wdata = 0; reg_be = 0;
    slv_rdata = '0; slv_ack = '0; err_clr = 0;
    last_rdata = 0; last_err = 0; last_cs = 0; cs_hi = 0;
    model_reset();
    @(posedge app_clk); #1;
    chk_en = 1;
    step(5'd0, 1'b0, 1'b0, 32'd0);
    app_rst = 0;
    idle(2);

    // read slot 1 offset 0x08, ack two cycles after select
    pin_en = 1; pin_val = 32'h1234_5678;
    do_txn(1'b0, {3'd1, 6'h08}, 32'h0, 4'hF, 2, -1, 1'b0);
    pin_en = 0;
    chk("r036_rdata", last_rdata, 32'h1234_5678);
    chk("r036_err", 32'(last_err), 32'd0);
    chk("r036_cs", 32'(last_cs), 32'b00010);
    chk("r036_addr", 32'(slv_addr), 32'h08);
    idle(1);

    // write slot 4, immediate ack
    do_txn(1'b1, {3'd4, 6'h3C}, 32'hA5A5_A5A5, 4'b0011, 0, -1, 1'b1);
    chk("r037_wdata", slv_wdata, 32'hA5A5_A5A5);
    chk("r037_be", 32'(slv_be), 32'b0011);
    chk("r037_rdata", last_rdata, 32'd0);
    idle(1);

    // decode error on slot 6
    cs_hi = 0;
    do_txn(1'b0, {3'd6, 6'h00}, 32'h0, 4'hF, 0, -1, 1'b0);
    chk("r038_err", 32'(last_err), 32'd1);
    chk("r038_rdata", last_rdata, 32'hDEAD_DEAD);
    chk("r038_nocs", 32'(cs_hi), 32'd0);
    chk("r038_sticky", 32'(err_sticky), 32'd1);
    chk("r038_cnt", 32'(err_cnt), 32'd1);
    idle(1);

    // timeout on slot 2, then ack on the final wait cycle
    cs_hi = 0;
    do_txn(1'b0, {3'd2, 6'h10}, 32'h0, 4'hF, 100, -1, 1'b0);
    chk("r039_cs_cycles", 32'(cs_hi), 32'd4);
    chk("r039_err", 32'(last_err), 32'd1);
    chk("r039_rdata", last_rdata, 32'hDEAD_DEAD);
    cs_hi = 0;
    do_txn(1'b0, {3'd2, 6'h14}, 32'h0, 4'hF, TO - 1, -1, 1'b0);
    chk("r039_last_cs", 32'(cs_hi), 32'd4);
    chk("r039_last_err", 32'(last_err), 32'd0);

    // abort while selected: select drops, counter untouched
    do_txn(1'b0, {3'd3, 6'h04}, 32'h0, 4'hF, 100, 1, 1'b0);
    chk("r041_abort_cs", 32'(slv_cs), 32'd0);
    chk("r041_abort_cnt", 32'(err_cnt), 32'd2);

    // reset in the middle of a request
    rand_inputs();
    reg_cs = 1; reg_wr = 1; reg_addr = {3'd0, 6'h2A}; reg_wdata = 32'h5555_AAAA; reg_be = 4'hC;
    step(5'd0, 1'b0, 1'b0, 32'd0);
    m_wr = 1; m_addr = 6'h2A; m_wdata = 32'h5555_AAAA; m_be = 4'hC;
    rand_inputs(); slv_ack[0] = 0;
    step(5'b00001, 1'b0, 1'b0, 32'd0);
    rand_inputs(); slv_ack[0] = 0; app_rst = 1;
    step(5'b00001, 1'b0, 1'b0, 32'd0);
    app_rst = 0;
    chk("r041_rst_cs", 32'(slv_cs), 32'd0);
    chk("r041_rst_cnt", 32'(err_cnt), 32'd0);
    chk("r041_rst_wdata", slv_wdata, 32'd0);
    idle(3);

    // saturation, clear, and error coinciding with clear
    for (int i = 0; i < 300; i++)
      do_txn(1'($urandom), {3'($urandom_range(5, 7)), 6'($urandom)}, $urandom, 4'($urandom), 0, -1, 1'($urandom));
    chk("r040_sat", 32'(err_cnt), 32'd255);
    rand_inputs(); reg_cs = 0; err_clr = 1;
    step(5'd0, 1'b0, 1'b0, 32'd0);
    err_clr = 0;
    chk("r040_clr_cnt", 32'(err_cnt), 32'd0);
    chk("r040_clr_sticky", 32'(err_sticky), 32'd0);
    do_txn(1'b0, {3'd7, 6'h01}, 32'h0, 4'hF, 0, -1, 1'b0);
    do_txn(1'b0, {3'd7, 6'h02}, 32'h0, 4'hF, 0, -1, 1'b0);
    clr_at_resp = 1;
    do_txn(1'b0, {3'd5, 6'h03}, 32'h0, 4'hF, 0, -1, 1'b0);
    clr_at_resp = 0;
    err_clr = 0;
    chk("r040_coincide_cnt", 32'(err_cnt), 32'd1);
    chk("r040_coincide_sticky", 32'(err_sticky), 32'd1);
    idle(1);

    // randomized traffic with clears, aborts and timeouts
    clr_en = 1;
    for (int i = 0; i < 400; i++) begin
      slot = $urandom_range(0, 7);
      d = $urandom_range(0, 6);
      a = -1;
      if (slot < NS && $urandom_range(0, 7) == 0)
        a = $urandom_range(0, (d < TO - 1) ? d : TO - 1);
      do_txn(1'($urandom), {3'(slot), 6'($urandom)}, $urandom, 4'($urandom), d, a, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    clr_en = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
